// File: rtl/dmux_dispatch_if.sv
`default_nettype none
// ============================================================================
// Module      : dmux_dispatch_if
// Description : Producer-side and lane-side handshake bundle for dmux_dispatch.
// Revision    : 1.0 - initial release
// ============================================================================
interface dmux_dispatch_if #(
    parameter int WIDTH = 16
);
    logic             mode;
    logic [7:0]       lane_en;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic [2:0]       in_dest;
    logic             in_ready;
    logic [7:0]       out_valid;
    logic [WIDTH-1:0] out_data;
    logic [7:0]       out_ready;
    logic [2:0]       sel;
    logic             busy;
    logic [15:0]      sent_count;

    modport master (
        output mode, lane_en, in_valid, in_data, in_dest, out_ready,
        input  in_ready, out_valid, out_data, sel, busy, sent_count
    );

    modport slave (
        input  mode, lane_en, in_valid, in_data, in_dest, out_ready,
        output in_ready, out_valid, out_data, sel, busy, sent_count
    );
endinterface
`default_nettype wire

// File: rtl/dmux_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : dmux_dispatch
// Description : One-entry registered stream router onto eight demux lanes.
// Revision    : 1.0 - initial release
// ============================================================================
module dmux_dispatch #(
    parameter int WIDTH = 16
) (
    input  wire logic        clk,
    input  wire logic        rst,
    dmux_dispatch_if.slave   bus
);
    localparam logic [0:0] S_EMPTY = 1'b0;
    localparam logic [0:0] S_FULL  = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_state_next;
    logic [WIDTH-1:0] r_data;
    logic [2:0]       r_sel;
    logic [2:0]       r_ptr;
    logic [15:0]      r_sent;

    logic [2:0]       w_rr_lane;
    logic             w_rr_found;
    logic [2:0]       w_cand;
    logic             w_cand_ok;
    logic             w_full;
    logic             w_depart;
    logic             w_in_ready;
    logic             w_accept;

    // Round-robin search starts at the pointer and wraps through all eight lanes.
    always_comb begin
        w_rr_lane  = 3'd0;
        w_rr_found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (!w_rr_found && bus.lane_en[r_ptr + 3'(i)]) begin
                w_rr_lane  = r_ptr + 3'(i);
                w_rr_found = 1'b1;
            end
        end
    end

    assign w_cand     = bus.mode ? bus.in_dest : w_rr_lane;
    assign w_cand_ok  = bus.mode ? bus.lane_en[bus.in_dest] : w_rr_found;
    assign w_full     = (r_state == S_FULL);
    assign w_depart   = w_full & bus.out_ready[r_sel];
    assign w_in_ready = w_cand_ok & (~w_full | w_depart);
    assign w_accept   = bus.in_valid & w_in_ready & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_EMPTY: if (w_accept)               w_state_next = S_FULL;
            S_FULL:  if (w_depart && !w_accept)  w_state_next = S_EMPTY;
            default:                             w_state_next = S_EMPTY;
        endcase
    end

    // Holding register, pointer and counter; lane and mask changes never touch a held word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
            r_sel  <= 3'd0;
            r_ptr  <= 3'd0;
            r_sent <= 16'd0;
        end else begin
            if (w_accept) begin
                r_data <= bus.in_data;
                r_sel  <= w_cand;
                if (!bus.mode) begin
                    r_ptr <= w_cand + 3'd1;
                end
            end
            if (w_depart) begin
                r_sent <= r_sent + 16'd1;
            end
        end
    end

    always_comb begin
        bus.in_ready   = w_in_ready;
        bus.out_valid  = w_full ? (8'b1 << r_sel) : 8'b0;
        bus.out_data   = r_data;
        bus.sel        = r_sel;
        bus.busy       = w_full;
        bus.sent_count = r_sent;
    end
endmodule
`default_nettype wire

// File: tb/tb_dmux_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmux_dispatch
// Description : Directed self-checking bench for dmux_dispatch.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmux_dispatch;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    dmux_dispatch_if #(.WIDTH(16)) bus ();

    dmux_dispatch #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [2:0] rr_exp [4];

    initial begin
        rr_exp[0] = 3'd2; rr_exp[1] = 3'd5; rr_exp[2] = 3'd7; rr_exp[3] = 3'd2;

        rst           = 1'b1;
        bus.mode      = 1'b0;
        bus.lane_en   = 8'hFF;
        bus.in_valid  = 1'b0;
        bus.in_data   = 16'h0000;
        bus.in_dest   = 3'd0;
        bus.out_ready = 8'h00;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("rst_out_valid", 32'(bus.out_valid), 32'h00);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_sent", 32'(bus.sent_count), 32'h0);
        check("rst_sel", 32'(bus.sel), 32'h0);
        check("rst_data", 32'(bus.out_data), 32'h0);

        // Full-rate stream over all lanes
        bus.out_ready = 8'hFF;
        bus.in_valid  = 1'b1;
        for (int k = 0; k < 10; k++) begin
            bus.in_data = 16'(k);
            #1;
            check("stream_in_ready", 32'(bus.in_ready), 32'h1);
            tick();
            check("stream_sel", 32'(bus.sel), 32'(k % 8));
            check("stream_valid", 32'(bus.out_valid), 32'(8'h01 << (k % 8)));
            check("stream_data", 32'(bus.out_data), 32'(k));
            check("stream_sent", 32'(bus.sent_count), 32'(k));
        end
        bus.in_valid = 1'b0;
        tick();
        check("stream_sent_final", 32'(bus.sent_count), 32'd10);
        check("stream_idle_busy", 32'(bus.busy), 32'h0);

        // Round-robin over a sparse mask, pointer left at lane 2
        bus.lane_en  = 8'b1010_0100;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.in_data = 16'h1000 + 16'(k);
            tick();
            check("rr_sel", 32'(bus.sel), 32'(rr_exp[k]));
            check("rr_valid", 32'(bus.out_valid), 32'(8'h01 << rr_exp[k]));
        end
        bus.in_valid = 1'b0;
        tick();
        check("rr_sent", 32'(bus.sent_count), 32'd14);

        // Backpressure on lane 3; a ready on lane 4 must not release it
        bus.lane_en   = 8'hFF;
        bus.mode      = 1'b1;
        bus.in_dest   = 3'd3;
        bus.out_ready = 8'h00;
        bus.in_data   = 16'hBEEF;
        bus.in_valid  = 1'b1;
        #1;
        check("bp_in_ready_empty", 32'(bus.in_ready), 32'h1);
        tick();
        check("bp_valid", 32'(bus.out_valid), 32'h08);
        check("bp_busy", 32'(bus.busy), 32'h1);
        bus.in_data   = 16'h5555;
        bus.out_ready = 8'h10;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("bp_in_ready_stall", 32'(bus.in_ready), 32'h0);
            tick();
            check("bp_hold_valid", 32'(bus.out_valid), 32'h08);
            check("bp_hold_data", 32'(bus.out_data), 32'hBEEF);
            check("bp_hold_sent", 32'(bus.sent_count), 32'd14);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 8'h08;
        tick();
        check("bp_release_busy", 32'(bus.busy), 32'h0);
        check("bp_release_sent", 32'(bus.sent_count), 32'd15);
        check("bp_release_valid", 32'(bus.out_valid), 32'h00);

        // Depart on lane 1 and accept for lane 6 on the same edge
        bus.out_ready = 8'h00;
        bus.in_dest   = 3'd1;
        bus.in_data   = 16'hAAAA;
        bus.in_valid  = 1'b1;
        tick();
        check("sim_a_valid", 32'(bus.out_valid), 32'h02);
        bus.out_ready = 8'h02;
        bus.in_dest   = 3'd6;
        bus.in_data   = 16'hBBBB;
        #1;
        check("sim_in_ready", 32'(bus.in_ready), 32'h1);
        tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 8'h00;
        check("sim_b_valid", 32'(bus.out_valid), 32'h40);
        check("sim_b_data", 32'(bus.out_data), 32'hBBBB);
        check("sim_busy", 32'(bus.busy), 32'h1);
        check("sim_sent", 32'(bus.sent_count), 32'd16);

        // Disabled destination and empty mask, with the lane-6 word departing
        bus.out_ready = 8'h40;
        bus.lane_en   = 8'hBF;
        #1;
        check("dis_dest_in_ready", 32'(bus.in_ready), 32'h0);
        bus.mode    = 1'b0;
        bus.lane_en = 8'h00;
        #1;
        check("dis_mask_in_ready", 32'(bus.in_ready), 32'h0);
        check("dis_held_valid", 32'(bus.out_valid), 32'h40);
        tick();
        check("dis_deliver_busy", 32'(bus.busy), 32'h0);
        check("dis_deliver_sent", 32'(bus.sent_count), 32'd17);

        // Reset while stalled; mode 0 would otherwise resume at lane 3
        bus.lane_en   = 8'hFF;
        bus.mode      = 1'b1;
        bus.in_dest   = 3'd5;
        bus.out_ready = 8'h00;
        bus.in_data   = 16'hCCCC;
        bus.in_valid  = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check("mr_held_valid", 32'(bus.out_valid), 32'h20);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mr_busy", 32'(bus.busy), 32'h0);
        check("mr_valid", 32'(bus.out_valid), 32'h00);
        check("mr_sent", 32'(bus.sent_count), 32'h0);
        bus.out_ready = 8'hFF;
        tick();
        check("mr_no_replay", 32'(bus.out_valid), 32'h00);
        check("mr_no_count", 32'(bus.sent_count), 32'h0);
        bus.mode     = 1'b0;
        bus.in_data  = 16'hDDDD;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check("mr_next_sel", 32'(bus.sel), 32'h0);
        check("mr_next_valid", 32'(bus.out_valid), 32'h01);
        check("mr_next_data", 32'(bus.out_data), 32'hDDDD);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/dmux_dispatch.md
# dmux_dispatch

Registered dispatcher that sequences a single-input, eight-output demultiplexer as a handshaked stream router. The block accepts one word per transfer on a valid/ready input and holds it in a one-entry output register. It picks a destination lane either round-robin over the enabled lanes or by an explicit destination field. It then drives the demux select and presents the word on that lane only until the lane accepts it. It sits between a single producer and eight consumer lanes wherever a DMux8Way-style split must be shared over time.

## Interface
- WIDTH, 16, data word width in bits
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- mode  input  1  0 = round-robin lane choice; 1 = lane taken from in_dest
- lane_en  input  8  per-lane enable mask; bit i enables lane i
- in_valid  input  1  producer has a word
- in_data  input  WIDTH  producer word
- in_dest  input  3  destination lane, used only when mode = 1
- in_ready  output  1  block accepts in_data this cycle
- out_valid  output  8  one-hot valid: bit sel set while the holding register is full, else all zero
- out_data  output  WIDTH  held word, shared by all lanes
- out_ready  input  8  per-lane consumer ready
- sel  output  3  lane of the held word; equals the demux select
- busy  output  1  holding register full
- sent_count  output  16  number of completed output transfers, wraps modulo 2^16

## Operation
- State: full (0 = EMPTY, 1 = FULL), holding register {data, sel}, round-robin pointer ptr[2:0], sent_count.
- Candidate lane, evaluated combinationally each cycle:
  - mode 0: first lane i with lane_en[i] = 1, scanning ptr, ptr+1, ... ptr+7 modulo 8.
  - mode 1: in_dest.
- cand_ok is 0 in two cases: mode 0 with lane_en all zero, or mode 1 with lane_en[in_dest] = 0. Otherwise cand_ok is 1.
- depart = full & out_ready[sel].
- in_ready = cand_ok & (~full | depart). Pass-through is allowed, so throughput is one word per cycle.
- accept = in_valid & in_ready. On accept:
  - load data and sel from the candidate lane.
  - full stays or becomes 1.
  - in mode 0, ptr <= cand + 1 mod 8. In mode 1, ptr is unchanged.
- On depart without accept: full <= 0, and data and sel keep their values.
- On depart: sent_count <= sent_count + 1, wrapping from 0xFFFF to 0.
- EMPTY -> FULL on accept. FULL -> EMPTY on depart & ~accept. FULL -> FULL on depart & accept (a new word and a possibly different lane load on the same edge). FULL holds while ~depart.
- out_valid = full ? (8'b1 << sel) : 8'b0. At most one bit is ever set.
- Changes to lane_en or mode while FULL do not affect the held word. It is still delivered to its latched sel, even if that lane is now disabled.
- out_ready bits of lanes other than sel are ignored.

## Timing
- Reset (synchronous, on the clock edge with reset = 1):
  - full = 0, ptr = 0, sel = 0, out_data = 0, sent_count = 0.
  - out_valid = 8'h00, busy = 0.
  - in_ready follows its combinational equation. During reset the block accepts nothing; accept is suppressed while reset = 1.
- Reset mid-operation discards the held word. It is not counted.
- Latency: a word accepted at edge N appears on out_valid/out_data from edge N to edge N+1. It departs at the first later edge with out_ready[sel] = 1. Minimum residency is one cycle.
- in_ready depends combinationally on out_ready[sel], lane_en, mode, and in_dest. in_valid must not depend on in_ready.
- out_valid, out_data, sel, busy, and sent_count are registered outputs with no combinational input paths.

## Test plan
- Reset then idle: check out_valid = 00, busy = 0, sent_count = 0. Then, with mode = 0, lane_en = FF and all out_ready = 1, stream 0x0000..0x0009 with in_valid held at 1. Required response:
  - sel cycles 0,1,...,7,0,1.
  - in_ready stays 1 throughout.
  - sent_count reaches 10 one cycle after the last accept.
- Round-robin with mask: mode = 0, lane_en = 8'b1010_0100, all ready, send 4 words. Required response: lanes 2, 5, 7, 2.
- Backpressure: mode = 1, in_dest = 3, out_ready = 00, send 0xBEEF. Required response:
  - out_valid = 08 and busy = 1.
  - in_ready = 0 for 5 cycles.
  - Raise out_ready[3]: the word departs that edge and sent_count increments by 1.
  - out_ready[4] = 1 has no effect during the stall.
- Simultaneous depart and accept: word A is held on lane 1. Set out_ready = 02 with word B on in_dest = 6 (mode 1). Required response: next cycle out_valid = 40, out_data = B, busy stays 1.
- Disabled destination and all-disabled mask:
  - mode 1 with lane_en[in_dest] = 0 gives in_ready = 0.
  - mode 0 with lane_en = 00 gives in_ready = 0.
  - A word already held on a lane that then becomes disabled is still delivered.
- Reset mid-transfer: while FULL and stalled, assert reset for one cycle. Required response:
  - busy = 0, out_valid = 00, sent_count = 0.
  - The held word is never presented again.
  - The next accept in mode 0 uses lane 0.
